// File: rtl/bldc_pkg.sv
// -----------------------------------------------------------------------------
// bldc_pkg
// Shared types and helpers for the six-step BLDC commutator.
//   state_t       : controller FSM states (IDLE / RUN / FAULT)
//   step_t        : commutation step index, 0..5
//   hall_map_t    : result of a hall lookup (valid flag + base step)
//   drive_t       : gate pattern for one step, bits ordered {C,B,A}
//   hall_to_step  : hall code -> base step (000/111 flagged invalid)
//   step_for_dir  : applies the half-turn offset for reverse rotation
//   step_drive    : step -> high/low side gate pattern
// -----------------------------------------------------------------------------
package bldc_pkg;

    localparam int HALL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    typedef logic [2:0] step_t;

    typedef struct packed {
        logic  valid;
        step_t step;
    } hall_map_t;

    typedef struct packed {
        logic [2:0] hs;
        logic [2:0] ls;
    } drive_t;

    function automatic hall_map_t hall_to_step(input logic [HALL_W-1:0] code);
        hall_map_t m;
        m = '{valid: 1'b1, step: 3'd0};
        case (code)
            3'b101:  m.step = 3'd0;
            3'b100:  m.step = 3'd1;
            3'b110:  m.step = 3'd2;
            3'b010:  m.step = 3'd3;
            3'b011:  m.step = 3'd4;
            3'b001:  m.step = 3'd5;
            default: m      = '{valid: 1'b0, step: 3'd0};
        endcase
        return m;
    endfunction

    // Reverse rotation is the same table shifted by half an electrical turn.
    function automatic step_t step_for_dir(input step_t base, input logic dir);
        step_t s;
        s = base;
        if (dir) begin
            s = (base >= 3'd3) ? base - 3'd3 : base + 3'd3;
        end
        return s;
    endfunction

    function automatic drive_t step_drive(input step_t s);
        drive_t d;
        d = '{hs: 3'b000, ls: 3'b000};
        case (s)
            3'd0:    d = '{hs: 3'b001, ls: 3'b010};  // A-hi / B-lo
            3'd1:    d = '{hs: 3'b001, ls: 3'b100};  // A-hi / C-lo
            3'd2:    d = '{hs: 3'b010, ls: 3'b100};  // B-hi / C-lo
            3'd3:    d = '{hs: 3'b010, ls: 3'b001};  // B-hi / A-lo
            3'd4:    d = '{hs: 3'b100, ls: 3'b001};  // C-hi / A-lo
            3'd5:    d = '{hs: 3'b100, ls: 3'b010};  // C-hi / B-lo
            default: d = '{hs: 3'b000, ls: 3'b000};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hall_filter.sv
// -----------------------------------------------------------------------------
// hall_filter
// Brings the asynchronous hall code into the clk domain through a 2-flop
// synchroniser, then accepts a new code only once the synchronised value has
// been seen unchanged on FILT_LEN consecutive cycles (FILT_LEN >= 2).
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset (clears sync, filter, code)
//   hall     in   raw hall code {C,B,A}
//   code     out  filtered, registered hall code (000 after reset = invalid)
// -----------------------------------------------------------------------------
module hall_filter
    import bldc_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [HALL_W-1:0] hall,
    output logic [HALL_W-1:0] code
);

    localparam int               CNT_W    = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic [HALL_W-1:0] sync1_q;
    logic [HALL_W-1:0] sync2_q;
    logic [HALL_W-1:0] cand_q;
    logic [CNT_W-1:0]  cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours; blocking here would
    // collapse the two synchroniser stages into one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            code    <= '0;
        end else begin
            sync1_q <= hall;
            sync2_q <= sync1_q;
            // cnt_q is the number of consecutive samples equal to cand_q;
            // the sample that loads a new candidate is the first of them.
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= CNT_W'(1);
            end else if (cnt_q >= CNT_LAST) begin
                code <= cand_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/six_step_commutator.sv
// -----------------------------------------------------------------------------
// six_step_commutator
// Hall-sensored six-step BLDC commutation controller with PWM on the high
// side, ramped duty, break-before-make on every step change, and fault
// handling for invalid hall codes.
// Optional build macro STALL_DETECT_EN adds a stall timer that faults the
// drive after STALL_CYC RUN cycles without a filtered hall change.
// Ports:
//   clk        in   clock, all state on rising edge
//   reset_n    in   asynchronous active-low reset
//   enable     in   run request
//   dir        in   0 forward, 1 reverse
//   hall       in   raw asynchronous hall code {C,B,A}
//   speed_set  in   target duty
//   hs         out  high-side gate enables {C,B,A} (PWM gated)
//   ls         out  low-side gate enables {C,B,A} (continuous)
//   duty       out  present ramped duty
//   step       out  present commutation step 0..5
//   fault      out  high while in FAULT
// -----------------------------------------------------------------------------
module six_step_commutator
    import bldc_pkg::*;
#(
    parameter int PWM_W     = 8,
    parameter int RAMP_DIV  = 16,
    parameter int FILT_LEN  = 4,
    parameter int STALL_CYC = 1048576
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              dir,
    input  logic [HALL_W-1:0] hall,
    input  logic [PWM_W-1:0]  speed_set,
    output logic [2:0]        hs,
    output logic [2:0]        ls,
    output logic [PWM_W-1:0]  duty,
    output step_t             step,
    output logic              fault
);

    localparam logic [PWM_W-1:0] PWM_LAST  = {{(PWM_W-1){1'b1}}, 1'b0};
    localparam int               RAMP_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

    logic [HALL_W-1:0] code;
    hall_map_t         hall_map;
    step_t             target;
    logic              stall;

    state_t            state_q, state_d;
    step_t             step_d;
    logic              step_change;
    drive_t            drv;
    logic [2:0]        hs_d, ls_d;
    logic              fault_d;
    logic [PWM_W-1:0]  duty_d;
    logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [PWM_W-1:0]  pwm_cnt_q;
    logic              pwm_on;

    hall_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_hall_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .hall    (hall),
        .code    (code)
    );

    assign hall_map = hall_to_step(code);
    assign target   = step_for_dir(hall_map.step, dir);

    // PWM carrier: 0 .. 2^PWM_W-2, so duty of all-ones is on every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q <= '0;
        end else if (pwm_cnt_q == PWM_LAST) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end

    assign pwm_on = (pwm_cnt_q < duty);

`ifdef STALL_DETECT_EN
    localparam int                STALL_W    = $clog2(STALL_CYC + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYC - 1);

    logic [HALL_W-1:0]  code_prev_q;
    logic [STALL_W-1:0] stall_cnt_q;

    // stall_cnt_q holds the number of RUN cycles since entry or the last
    // filtered-code change; FAULT is taken on the edge that would reach
    // STALL_CYC.
    assign stall = (state_q == ST_RUN) && (code == code_prev_q) &&
                   (stall_cnt_q == STALL_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_prev_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            code_prev_q <= code;
            if (state_d != ST_RUN || code != code_prev_q) begin
                stall_cnt_q <= '0;
            end else begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end
`else
    logic stall_cyc_unused;
    assign stall_cyc_unused = (STALL_CYC != 0);
    assign stall            = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        step_d      = step;
        hs_d        = '0;
        ls_d        = '0;
        duty_d      = duty;
        ramp_cnt_d  = ramp_cnt_q;
        drv         = step_drive(step);

        // Fault outranks enable, which outranks any step change.
        unique case (state_q)
            ST_IDLE:  if (enable && hall_map.valid) state_d = ST_RUN;
            ST_RUN: begin
                if (!hall_map.valid || stall) begin
                    state_d = ST_FAULT;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: if (!enable) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Step tracks the hall in every state so RUN starts on the right step;
        // an invalid code holds the last good step.
        if (hall_map.valid) begin
            step_d = target;
        end
        step_change = (step_d != step);

        // The edge that moves step drives all gates off; the new pattern is
        // produced on the next edge from the updated step register.
        if (state_d == ST_RUN && !step_change) begin
            hs_d = drv.hs & {3{pwm_on}};
            ls_d = drv.ls;
        end

        fault_d = (state_d == ST_FAULT);

        if (state_d != ST_RUN) begin
            duty_d     = '0;
            ramp_cnt_d = '0;
        end else if (ramp_cnt_q == RAMP_LAST) begin
            ramp_cnt_d = '0;
            if (duty < speed_set) begin
                duty_d = duty + 1'b1;
            end else if (duty > speed_set) begin
                duty_d = duty - 1'b1;
            end
        end else begin
            ramp_cnt_d = ramp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step       <= '0;
            hs         <= '0;
            ls         <= '0;
            duty       <= '0;
            fault      <= 1'b0;
            ramp_cnt_q <= '0;
        end else begin
            step       <= step_d;
            hs         <= hs_d;
            ls         <= ls_d;
            duty       <= duty_d;
            fault      <= fault_d;
            ramp_cnt_q <= ramp_cnt_d;
        end
    end

endmodule

// File: tb/tb_six_step_commutator.sv
// -----------------------------------------------------------------------------
// tb_six_step_commutator
// Directed bench for six_step_commutator (PWM_W=8, RAMP_DIV=16, FILT_LEN=4).
// With STALL_DETECT_EN defined a second instance with STALL_CYC=100 is added
// for the stall scenario.
// -----------------------------------------------------------------------------
module tb_six_step_commutator;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       dir = 1'b0;
    logic [2:0] hall = 3'b101;
    logic [7:0] speed_set = 8'h00;
    logic [2:0] hs, ls, step;
    logic [7:0] duty;
    logic       fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    six_step_commutator #(
        .PWM_W(8), .RAMP_DIV(16), .FILT_LEN(4), .STALL_CYC(4000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .dir(dir), .hall(hall),
        .speed_set(speed_set), .hs(hs), .ls(ls), .duty(duty), .step(step),
        .fault(fault)
    );

`ifdef STALL_DETECT_EN
    logic [2:0] hs_s, ls_s, step_s;
    logic [7:0] duty_s;
    logic       fault_s;

    six_step_commutator #(
        .PWM_W(8), .RAMP_DIV(16), .FILT_LEN(4), .STALL_CYC(100)
    ) dut_stall (
        .clk(clk), .reset_n(reset_n), .enable(enable), .dir(dir), .hall(hall),
        .speed_set(speed_set), .hs(hs_s), .ls(ls_s), .duty(duty_s),
        .step(step_s), .fault(fault_s)
    );
`endif

    function automatic logic [2:0] exp_ls(input logic [2:0] s);
        case (s)
            3'd0: return 3'b010;
            3'd1: return 3'b100;
            3'd2: return 3'b100;
            3'd3: return 3'b001;
            3'd4: return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [2:0] exp_hs(input logic [2:0] s);
        case (s)
            3'd0: return 3'b001;
            3'd1: return 3'b001;
            3'd2: return 3'b010;
            3'd3: return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; dir = 1'b0; hall = 3'b101; speed_set = 8'h00;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; hall = 3'b101;
        repeat (2) tick();
        checks++; if (hs !== 3'b000) begin errors++; $display("FAIL reset_hs: got %b expected 000", hs); end
        checks++; if (ls !== 3'b000) begin errors++; $display("FAIL reset_ls: got %b expected 000", ls); end
        checks++; if (duty !== 8'h00) begin errors++; $display("FAIL reset_duty: got %h expected 00", duty); end
        checks++; if (step !== 3'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", step); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
        reset_n = 1'b1;
        repeat (20) tick();
        checks++; if ({hs, ls, fault} !== 7'b0) begin errors++; $display("FAIL idle_outputs: got hs=%b ls=%b fault=%b expected all 0", hs, ls, fault); end
    endtask

    task automatic test_ramp_run();
        int n;
        int on_cnt;
        int bad;
        do_reset();
        speed_set = 8'h80;
        enable = 1'b1;
        tick();
        n = 1;
        checks++; if (ls !== 3'b010 || step !== 3'd0 || fault !== 1'b0) begin
            errors++; $display("FAIL run_entry: got ls=%b step=%0d fault=%b expected ls=010 step=0 fault=0", ls, step, fault);
        end
        while (duty !== 8'h80 && n < 3000) begin
            tick();
            n++;
        end
        checks++; if (n !== 2048) begin errors++; $display("FAIL ramp_up_time: got %0d cycles expected 2048", n); end
        on_cnt = 0; bad = 0;
        repeat (255) begin
            tick();
            if (hs[0] === 1'b1) on_cnt++;
            if (hs[2:1] !== 2'b00 || ls !== 3'b010 || (hs & ls) !== 3'b000) bad++;
        end
        checks++; if (on_cnt !== 128) begin errors++; $display("FAIL pwm_50pct: got %0d on-cycles of 255 expected 128", on_cnt); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL pwm_pattern: got %0d bad cycles expected 0", bad); end
        speed_set = 8'h7C;
        repeat (84) tick();
        checks++; if (duty !== 8'h7C) begin errors++; $display("FAIL ramp_down: got %h expected 7c", duty); end
        repeat (40) tick();
        checks++; if (duty !== 8'h7C) begin errors++; $display("FAIL ramp_hold: got %h expected 7c", duty); end
    endtask

    task automatic test_sequence(input logic d);
        logic [2:0] halls [6];
        logic [2:0] exp_s, prev;
        int n, viol;
        halls = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
        do_reset();
        dir = d; speed_set = 8'h40;
        repeat (4) tick();
        enable = 1'b1;
        tick();
        exp_s = d ? 3'd3 : 3'd0;
        checks++; if (step !== exp_s || ls !== exp_ls(exp_s)) begin
            errors++; $display("FAIL seq_start dir=%b: got step=%0d ls=%b expected step=%0d ls=%b", d, step, ls, exp_s, exp_ls(exp_s));
        end
        viol = 0;
        repeat (999) begin
            tick();
            if ((hs & ls) !== 3'b000 || step !== exp_s) viol++;
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL seq_hold0 dir=%b: got %0d bad cycles expected 0", d, viol); end
        for (int i = 1; i < 6; i++) begin
            prev  = exp_s;
            exp_s = d ? 3'((i + 3) % 6) : 3'(i);
            hall  = halls[i];
            n = 0;
            do begin
                tick();
                n++;
            end while (step === prev && n < 40);
            checks++; if (step !== exp_s) begin errors++; $display("FAIL seq_step dir=%b i=%0d: got %0d expected %0d", d, i, step, exp_s); end
            checks++; if ({hs, ls} !== 6'b0) begin errors++; $display("FAIL seq_bbm dir=%b i=%0d: got hs=%b ls=%b expected 000 000", d, i, hs, ls); end
            tick();
            n++;
            checks++; if (ls !== exp_ls(exp_s)) begin errors++; $display("FAIL seq_ls dir=%b i=%0d: got %b expected %b", d, i, ls, exp_ls(exp_s)); end
            checks++; if ((hs & ~exp_hs(exp_s)) !== 3'b000) begin errors++; $display("FAIL seq_hs dir=%b i=%0d: got %b allowed %b", d, i, hs, exp_hs(exp_s)); end
            viol = 0;
            while (n < 1000) begin
                tick();
                n++;
                if ((hs & ls) !== 3'b000 || step !== exp_s || ls !== exp_ls(exp_s)) viol++;
            end
            checks++; if (viol !== 0) begin errors++; $display("FAIL seq_hold dir=%b i=%0d: got %0d bad cycles expected 0", d, i, viol); end
        end
    endtask

    task automatic test_glitch();
        int bad;
        logic saw;
        do_reset();
        speed_set = 8'h40;
        enable = 1'b1;
        repeat (50) tick();
        hall = 3'b100;
        repeat (2) tick();
        hall = 3'b101;
        bad = 0;
        repeat (30) begin
            tick();
            if (step !== 3'd0 || ls !== 3'b010) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL glitch_2cyc: got %0d disturbed cycles expected 0", bad); end
        hall = 3'b100;
        repeat (4) tick();
        hall = 3'b101;
        saw = 1'b0;
        repeat (30) begin
            tick();
            if (step === 3'd1) saw = 1'b1;
        end
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL pulse_4cyc: got no step 1 expected step 1 seen"); end
        checks++; if (step !== 3'd0) begin errors++; $display("FAIL pulse_return: got %0d expected 0", step); end
    endtask

    task automatic test_hall_fault();
        int n;
        do_reset();
        speed_set = 8'h40;
        enable = 1'b1;
        repeat (40) tick();
        hall = 3'b111;
        n = 0;
        while (fault !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_set: got %b expected 1", fault); end
        checks++; if ({hs, ls} !== 6'b0 || duty !== 8'h00) begin
            errors++; $display("FAIL fault_outputs: got hs=%b ls=%b duty=%h expected all 0", hs, ls, duty);
        end
        hall = 3'b101;
        repeat (30) tick();
        checks++; if (fault !== 1'b1 || ls !== 3'b000) begin errors++; $display("FAIL fault_hold: got fault=%b ls=%b expected 1 000", fault, ls); end
        enable = 1'b0;
        tick();
        checks++; if (fault !== 1'b0 || ls !== 3'b000) begin errors++; $display("FAIL fault_clear: got fault=%b ls=%b expected 0 000", fault, ls); end
        enable = 1'b1;
        tick();
        checks++; if (fault !== 1'b0 || ls !== 3'b010) begin errors++; $display("FAIL fault_rerun: got fault=%b ls=%b expected 0 010", fault, ls); end
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        speed_set = 8'h40;
        enable = 1'b1;
`ifdef STALL_DETECT_EN
        n = 0;
        while (fault_s !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++; if (n !== 100) begin errors++; $display("FAIL stall_time: got %0d cycles expected 100", n); end
        checks++; if ({hs_s, ls_s} !== 6'b0) begin errors++; $display("FAIL stall_outputs: got hs=%b ls=%b expected 000 000", hs_s, ls_s); end
`else
        n = 0;
        repeat (300) begin
            tick();
            if (fault !== 1'b0 || ls !== 3'b010) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL no_stall: got %0d non-RUN cycles expected 0", n); end
`endif
    endtask

    task automatic test_reset_mid_ramp();
        do_reset();
        hall = 3'b110;
        repeat (20) tick();
        speed_set = 8'hFF;
        enable = 1'b1;
        repeat (200) tick();
        checks++; if (duty !== 8'd12 || step !== 3'd2 || ls !== 3'b100) begin
            errors++; $display("FAIL mid_ramp: got duty=%0d step=%0d ls=%b expected 12 2 100", duty, step, ls);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if ({hs, ls, fault} !== 7'b0 || duty !== 8'h00 || step !== 3'd0) begin
            errors++; $display("FAIL async_reset: got hs=%b ls=%b duty=%h step=%0d fault=%b expected all 0", hs, ls, duty, step, fault);
        end
        enable = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ramp_run();
        test_sequence(1'b0);
        test_sequence(1'b1);
        test_glitch();
        test_hall_fault();
        test_stall();
        test_reset_mid_ramp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
